// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller: tag lookup through the line RAM,
// four-beat line refill from memory, and a full-array invalidate sweep after reset or flush.
module icache_ctrl #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 22,
  parameter int unsigned LINE_W  = 151
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req_valid,
  input  logic [31:0]        cpu_req_addr,
  output logic               cpu_req_ready,
  output logic               cpu_resp_valid,
  output logic [31:0]        cpu_resp_data,
  input  logic               flush_req,
  output logic               busy,
  output logic               mem_rd_req,
  output logic [31:0]        mem_rd_addr,
  input  logic               mem_rd_ready,
  input  logic               mem_rd_valid,
  input  logic [31:0]        mem_rd_data,
  output logic [INDEX_W-1:0] ram_r_index,
  input  logic [LINE_W-1:0]  ram_rdata,
  output logic               ram_we,
  output logic [INDEX_W-1:0] ram_w_index,
  output logic [LINE_W-1:0]  ram_wdata
);

  typedef enum logic [2:0] {StInit, StIdle, StLookup, StMissReq, StRefill, StFill} state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] k_q, k_d;
  logic [31:2]        addr_q, addr_d;
  logic [1:0]         beat_q, beat_d;
  logic [3:0][31:0]   line_q, line_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;

  logic [3:0][31:0]   ram_words;
  logic               hit;
  logic               unused_addr;

  assign unused_addr = ^cpu_req_addr[1:0];
  assign ram_words   = ram_rdata[127:0];
  assign hit         = ram_rdata[LINE_W-1] &&
                       (ram_rdata[LINE_W-2 -: TAG_W] == addr_q[31 -: TAG_W]);

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    addr_d        = addr_q;
    beat_d        = beat_q;
    line_d        = line_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    cpu_req_ready = 1'b0;
    busy          = (state_q != StIdle);
    ram_r_index   = addr_q[4 +: INDEX_W];
    ram_we        = 1'b0;
    ram_w_index   = '0;
    ram_wdata     = '0;
    mem_rd_req    = 1'b0;
    mem_rd_addr   = '0;

    unique case (state_q)
      StInit: begin
        ram_we      = 1'b1;
        ram_w_index = k_q;
        k_d         = k_q + 1'b1;
        if (k_q == '1) state_d = StIdle;
      end
      StIdle: begin
        if (flush_req) begin
          state_d = StInit;
          k_d     = '0;
        end else begin
          cpu_req_ready = 1'b1;
          ram_r_index   = cpu_req_addr[4 +: INDEX_W];
          if (cpu_req_valid) begin
            addr_d  = cpu_req_addr[31:2];
            state_d = StLookup;
          end
        end
      end
      StLookup: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_data_d  = ram_words[addr_q[3:2]];
          state_d      = StIdle;
        end else begin
          state_d = StMissReq;
        end
      end
      StMissReq: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {addr_q[31:4], 4'b0};
        if (mem_rd_ready) begin
          beat_d  = '0;
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (mem_rd_valid) begin
          line_d[beat_q] = mem_rd_data;
          beat_d         = beat_q + 1'b1;
          if (beat_q == 2'd3) state_d = StFill;
        end
      end
      StFill: begin
        ram_we       = 1'b1;
        ram_w_index  = addr_q[4 +: INDEX_W];
        ram_wdata    = {1'b1, addr_q[31 -: TAG_W], line_q};
        resp_valid_d = 1'b1;
        resp_data_d  = line_q[addr_q[3:2]];
        state_d      = StIdle;
      end
      default: state_d = StInit;
    endcase

    // Outputs are held at zero for as long as reset is asserted.
    if (rst) begin
      cpu_req_ready = 1'b0;
      busy          = 1'b0;
      ram_r_index   = '0;
      ram_we        = 1'b0;
      ram_w_index   = '0;
      ram_wdata     = '0;
      mem_rd_req    = 1'b0;
      mem_rd_addr   = '0;
    end
  end

  assign cpu_resp_valid = resp_valid_q & ~rst;
  assign cpu_resp_data  = rst ? 32'h0 : resp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      k_q          <= '0;
      addr_q       <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed fetches push expected responses and RAM writes,
// negedge monitors pop and compare whatever the controller presents.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req_valid = 1'b0;
  logic [31:0]  cpu_req_addr = '0;
  logic         cpu_req_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_data;
  logic         flush_req = 1'b0;
  logic         busy;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_ready = 1'b0;
  logic         mem_rd_valid = 1'b0;
  logic [31:0]  mem_rd_data = '0;
  logic [5:0]   ram_r_index;
  logic [150:0] ram_rdata;
  logic         ram_we;
  logic [5:0]   ram_w_index;
  logic [150:0] ram_wdata;

  logic [150:0] ram_mem [64];

  int tests = 0;
  int fails = 0;

  logic [31:0]  resp_q [$];
  logic [156:0] wr_q [$];

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_ready (cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data (cpu_resp_data),
    .flush_req     (flush_req),
    .busy          (busy),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_ready  (mem_rd_ready),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .ram_r_index   (ram_r_index),
    .ram_rdata     (ram_rdata),
    .ram_we        (ram_we),
    .ram_w_index   (ram_w_index),
    .ram_wdata     (ram_wdata)
  );

  // Line RAM model: registered read with write bypass.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_w_index] <= ram_wdata;
    ram_rdata <= (ram_we && ram_w_index == ram_r_index) ? ram_wdata : ram_mem[ram_r_index];
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    logic [31:0]  er;
    logic [156:0] ew;
    if (cpu_resp_valid) begin
      if (resp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: got data %h, expected no response", cpu_resp_data);
      end else begin
        er = resp_q.pop_front();
        check("resp_data", {128'h0, cpu_resp_data}, {128'h0, er});
      end
    end
    if (ram_we) begin
      if (wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ram_write_unexpected: got idx %h data %h, expected no write",
                 ram_w_index, ram_wdata);
      end else begin
        ew = wr_q.pop_front();
        check("ram_write", {3'b0, ram_w_index, ram_wdata}, {3'b0, ew});
      end
    end
  end

  task automatic check_zero(input string name);
    check(name, {79'h0, cpu_req_ready, cpu_resp_valid, cpu_resp_data, busy, mem_rd_req,
                 mem_rd_addr, ram_we, ram_w_index, ram_r_index}, 160'h0);
    check({name, "_wdata"}, {9'h0, ram_wdata}, 160'h0);
  endtask

  // Expects the controller to be in sweep cycle 0 at the next negedge.
  task automatic sweep();
    for (int i = 0; i < 64; i++) wr_q.push_back({i[5:0], 151'h0});
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("sweep_busy", {159'h0, busy}, 160'h1);
    end
    @(negedge clk);
    check("sweep_done_ready_busy", {158'h0, cpu_req_ready, busy}, 160'h2);
  endtask

  task automatic fetch(input logic [31:0] addr);
    int n = 0;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    #1;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cpu_req_ready) begin
      tests++;
      fails++;
      $display("FAIL fetch_accept: got ready=0, expected ready=1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic hit_fetch(input logic [31:0] addr);
    fetch(addr);
    @(negedge clk);
    check("hit_lookup_no_memreq", {159'h0, mem_rd_req}, 160'h0);
    @(negedge clk);
    check("hit_resp_lat_no_memreq", {158'h0, cpu_resp_valid, mem_rd_req}, 160'h2);
  endtask

  // Serves a miss after fetch(); nbeats < 4 stops after that many beats.
  task automatic serve_miss(input logic [31:0] exp_addr, input logic [3:0][31:0] beats,
                            input logic [5:0] idx, input int nbeats);
    int n = 0;
    while (!mem_rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("miss_req_latency", 160'(n), 160'd2);
    check("miss_rd_addr", {128'h0, mem_rd_addr}, {128'h0, exp_addr});
    if (!mem_rd_req) return;
    mem_rd_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_rd_ready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = beats[i];
      @(posedge clk);
      #1;
    end
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    if (nbeats < 4) return;
    @(negedge clk);
    check("fill_we_index", {153'h0, ram_we, ram_w_index}, {153'h0, 1'b1, idx});
    @(negedge clk);
    check("fill_resp_valid", {159'h0, cpu_resp_valid}, 160'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and initial sweep
    @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sweep();

    // Cold miss
    resp_q.push_back(32'hA1);
    wr_q.push_back({6'h23, 1'b1, 22'h4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
    fetch(32'h0000_1234);
    serve_miss(32'h0000_1230, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 6'h23, 4);

    // Hit in the refilled line
    resp_q.push_back(32'hA2);
    hit_fetch(32'h0000_1238);

    // Conflict at the same index, then the original line misses again
    resp_q.push_back(32'hB1);
    wr_q.push_back({6'h23, 1'b1, 22'h5, 32'hB3, 32'hB2, 32'hB1, 32'hB0});
    fetch(32'h0000_1634);
    serve_miss(32'h0000_1630, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 6'h23, 4);
    resp_q.push_back(32'hC1);
    wr_q.push_back({6'h23, 1'b1, 22'h4, 32'hC3, 32'hC2, 32'hC1, 32'hC0});
    fetch(32'h0000_1234);
    serve_miss(32'h0000_1230, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 6'h23, 4);
    // Earliest possible refetch of the just-filled line
    resp_q.push_back(32'hC3);
    hit_fetch(32'h0000_123C);

    // Flush beats a simultaneous request
    @(negedge clk);
    flush_req     = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_1234;
    #1;
    check("flush_prio_ready_busy", {158'h0, cpu_req_ready, busy}, 160'h0);
    @(posedge clk);
    #1;
    flush_req     = 1'b0;
    cpu_req_valid = 1'b0;
    sweep();
    resp_q.push_back(32'hD1);
    wr_q.push_back({6'h23, 1'b1, 22'h5, 32'hD3, 32'hD2, 32'hD1, 32'hD0});
    fetch(32'h0000_1634);
    serve_miss(32'h0000_1630, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 6'h23, 4);

    // Reset after two refill beats
    fetch(32'h0000_2004);
    serve_miss(32'h0000_2000, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 6'h00, 2);
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort_outputs_a");
    @(posedge clk);
    @(negedge clk);
    check_zero("abort_outputs_b");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sweep();

    // Line content was swept away by the reset
    resp_q.push_back(32'hE1);
    wr_q.push_back({6'h23, 1'b1, 22'h4, 32'hE3, 32'hE2, 32'hE1, 32'hE0});
    fetch(32'h0000_1234);
    serve_miss(32'h0000_1230, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 6'h23, 4);
    resp_q.push_back(32'hE0);
    hit_fetch(32'h0000_1230);

    repeat (5) @(negedge clk);
    check("resp_queue_drained", 160'(resp_q.size()), 160'h0);
    check("write_queue_drained", 160'(wr_q.size()), 160'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller that sequences the 64-entry × 151-bit dual-read cache line RAM. It accepts word fetches from the front end, performs the tag lookup through RAM read port 1, refills missing lines from the memory side as four 32-bit beats, and writes the completed line back into the RAM. It also runs a full-array invalidate sweep after reset and on flush, so the RAM array itself needs no reset.

## Interface
Parameters:
- INDEX_W, 6, set index width (64 sets)
- TAG_W, 22, tag width
- LINE_W, 151, RAM entry width: [150] valid, [149:128] tag, [127:0] data, word0 at [31:0]

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req_valid  in  1  fetch request
- cpu_req_addr  in  32  fetch byte address: tag [31:10], index [9:4], word [3:2], [1:0] ignored
- cpu_req_ready  out  1  request accepted when valid & ready
- cpu_resp_valid  out  1  one-cycle pulse, response data valid
- cpu_resp_data  out  32  fetched word
- flush_req  in  1  invalidate all lines (level, sampled in IDLE)
- busy  out  1  high in any state other than IDLE
- mem_rd_req  out  1  line read request, held until mem_rd_ready
- mem_rd_addr  out  32  line-aligned address ([3:0]=0)
- mem_rd_ready  in  1  memory accepts request
- mem_rd_valid  in  1  refill beat valid
- mem_rd_data  in  32  refill beat, ascending word order
- ram_r_index  out  6  to RAM r_index1
- ram_rdata  in  151  from RAM data_out1, registered (1-cycle latency), with write bypass
- ram_we, ram_w_index[5:0], ram_wdata[150:0]  out  RAM write port

## Operation
- States: INIT, IDLE, LOOKUP, MISS_REQ, REFILL, FILL.
- INIT: 6-bit counter k from 0; each cycle ram_we=1, ram_w_index=k, ram_wdata=0; after k=63 go to IDLE.
- IDLE: cpu_req_ready=1 unless flush_req=1. flush_req takes precedence over simultaneous cpu_req_valid: request not accepted, go to INIT with k=0. On accept, latch address; ram_r_index = cpu_req_addr[9:4] combinationally; go to LOOKUP.
- LOOKUP: hit = ram_rdata[150] & (ram_rdata[149:128] == latched tag). Hit: register selected word into cpu_resp_data, cpu_resp_valid=1 next cycle, go to IDLE. Miss: go to MISS_REQ.
- MISS_REQ: mem_rd_req=1, mem_rd_addr={addr[31:4],4'b0}; on mem_rd_ready go to REFILL, beat counter=0.
- REFILL: each mem_rd_valid stores mem_rd_data at word[counter], counter+1; on 4th beat go to FILL. mem_rd_valid outside REFILL ignored.
- FILL: ram_we=1, ram_w_index=latched index, ram_wdata={1'b1, tag, w3,w2,w1,w0}; requested word registered, cpu_resp_valid=1 next cycle; go to IDLE.
- Replacement: miss always overwrites the indexed line (no dirty state; read-only cache).

## Timing
- Reset values: all outputs 0 (cpu_req_ready, cpu_resp_valid, cpu_resp_data, mem_rd_req, mem_rd_addr, ram_*); state INIT, k=0; busy=1 only from first non-reset cycle.
- rst asserted in any state (including mid-refill) aborts: partial line discarded, no RAM write, no response; memory side must be reset with it.
- First cycle with rst low = sweep cycle 0 (index 0); index 63 at cycle 63; IDLE and cpu_req_ready=1 at cycle 64.
- Hit: accept cycle N, LOOKUP N+1, cpu_resp_valid N+2; next request acceptable at N+2 (one fetch per 2 cycles).
- Miss: mem_rd_req at N+2; FILL the cycle after the 4th beat; cpu_resp_valid the cycle after FILL.
- Request at same index immediately after FILL hits via RAM write bypass.
- cpu_resp_valid exactly one cycle per accepted request; no responses for flushed or aborted requests.

## Test plan
- Reset sweep: rst high 2 cycles then low -> ram_we=1 for 64 consecutive cycles, ram_w_index 0..63, ram_wdata=0; cpu_req_ready=1 at cycle 64.
- Cold miss: fetch 0x0000_1234 -> mem_rd_addr=0x0000_1230; beats 0xA0,0xA1,0xA2,0xA3 -> ram write index 0x23, wdata {1, tag 0x000004, A3,A2,A1,A0}; cpu_resp_data=0xA1.
- Hit: then fetch 0x0000_1238 -> cpu_resp_data=0xA2 two cycles after accept, mem_rd_req stays 0.
- Conflict: fetch 0x0000_1634 (index 0x23, tag 5) -> miss, refill with 0xB0..0xB3, resp 0xB1; refetch 0x0000_1234 misses again.
- Flush priority: flush_req and cpu_req_valid together in IDLE -> request not accepted, 64-cycle zero sweep, busy=1 throughout; afterwards 0x0000_1634 misses.
- Reset mid-refill after 2 beats -> all outputs 0 next cycle, no FILL write, no cpu_resp_valid, sweep restarts from index 0.
